// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for a common-anode 4-digit 7-segment
//                display. Scans the four digit slots with a blanking dead
//                time at the start of each slot. Takes a frame-coherent
//                snapshot of the digit inputs, decodes them as hex, and
//                supports a per-digit decimal point and optional
//                leading-zero blanking.
//  Ports       : clk          system clock
//                reset        synchronous, active-high reset
//                units        digit 0 value (rightmost)
//                tens         digit 1 value
//                hundreds     digit 2 value
//                thousands    digit 3 value (leftmost)
//                dp_en        decimal-point enable, bit i = digit i
//                lz_blank     1 = blank leading zeros
//                SEG          {dp,g,f,e,d,c,b,a}, active-low
//                DIGIT        anode enables, bit i = digit i, active-low
//                frame_start  one-cycle pulse at the start of each frame
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,  // clock cycles per digit slot (>= 4)
    parameter int DEAD     = 500     // dark cycles at the start of each slot
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic [3:0] dp_en,
    input  logic       lz_blank,
    output logic [7:0] SEG,
    output logic [3:0] DIGIT,
    output logic       frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_dead     = CNT_W'(DEAD);

    // Scan position
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;

    // Frame snapshot; digits packed as {thousands, hundreds, tens, units}
    logic [15:0]      r_snap_val;
    logic [3:0]       r_snap_dp;
    logic             r_snap_lz;

    logic             w_frame_edge;
    logic             w_lit;
    logic [3:0]       w_cur_val;
    logic             w_blank;
    logic [6:0]       w_seg_lo;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The snapshot is taken at the edge that ends the first cycle of a frame.
    assign w_frame_edge = (r_idx == 2'd0) && (r_cnt == '0);
    assign w_lit        = (r_cnt >= c_dead);
    assign w_cur_val    = r_snap_val[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    // The units digit is always shown so that a zero value still displays "0".
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3: w_blank = r_snap_lz && (r_snap_val[15:12] == 4'h0);
            2'd2: w_blank = r_snap_lz && (r_snap_val[15:8] == 8'h00);
            2'd1: w_blank = r_snap_lz && (r_snap_val[15:4] == 12'h000);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_seg_lo = w_blank ? 7'h7F : hex_to_seg(w_cur_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_snap_val  <= 16'h0000;
            r_snap_dp   <= 4'h0;
            r_snap_lz   <= 1'b0;
            SEG         <= 8'hFF;
            DIGIT       <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_frame_edge) begin
                r_snap_val <= {thousands, hundreds, tens, units};
                r_snap_dp  <= dp_en;
                r_snap_lz  <= lz_blank;
            end

            // Outputs are registered from the current scan state, giving one
            // cycle of latency; cnt==0 is always dark since DEAD >= 1.
            if (w_lit) begin
                SEG   <= {~r_snap_dp[r_idx], w_seg_lo};
                DIGIT <= ~(4'b0001 << r_idx);
            end else begin
                SEG   <= 8'hFF;
                DIGIT <= 4'hF;
            end

            frame_start <= w_frame_edge;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (SCAN_DIV=8, DEAD=2).
//                A frame/slot model predicts the outputs on every cycle;
//                directed literal checks pin key display values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] units = 4'h0;
    logic [3:0] tens = 4'h0;
    logic [3:0] hundreds = 4'h0;
    logic [3:0] thousands = 4'h0;
    logic [3:0] dp_en = 4'h0;
    logic       lz_blank = 1'b0;
    logic [7:0] SEG;
    logic [3:0] DIGIT;
    logic       frame_start;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
        .clk         (clk),
        .reset       (reset),
        .units       (units),
        .tens        (tens),
        .hundreds    (hundreds),
        .thousands   (thousands),
        .dp_en       (dp_en),
        .lz_blank    (lz_blank),
        .SEG         (SEG),
        .DIGIT       (DIGIT),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Display code table exactly as listed for the hex digits (dp off)
    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // ---------------- model ----------------
    bit         valid = 1'b0;
    int         n = 0;                 // edges since reset released
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    logic       m_lz;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fs;
    int         slot, pos, msnz;
    logic [7:0] code;

    always @(posedge clk) begin
        if (reset) begin
            valid = 1'b1;
            n     = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_dp  = 4'h0;
            m_lz  = 1'b0;
            e_seg = 8'hFF;
            e_dig = 4'hF;
            e_fs  = 1'b0;
        end else if (valid) begin
            slot = (n / SCAN_DIV) % 4;
            pos  = n % SCAN_DIV;
            e_fs = (n % FRAME == 0);
            if (pos < DEAD) begin
                e_seg = 8'hFF;
                e_dig = 4'hF;
            end else begin
                // most significant non-zero digit position (0 if all zero)
                msnz = 0;
                for (int i = 1; i < 4; i++) if (m_dig[i] != 4'h0) msnz = i;
                code = seg_tbl[m_dig[slot]];
                if (m_lz && slot > msnz) code = 8'hFF;
                code[7] = ~m_dp[slot];
                e_seg = code;
                e_dig = 4'hF;
                e_dig[slot] = 1'b0;
            end
            if (n % FRAME == 0) begin
                m_dig[0] = units;
                m_dig[1] = tens;
                m_dig[2] = hundreds;
                m_dig[3] = thousands;
                m_dp     = dp_en;
                m_lz     = lz_blank;
            end
            n++;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (valid) begin
            chk("model_seg",   SEG,                 e_seg);
            chk("model_digit", {4'h0, DIGIT},       {4'h0, e_dig});
            chk("model_fs",    {7'h0, frame_start}, {7'h0, e_fs});
        end
    end

    // Move to the negedge just after edge k (output reflects prior position k)
    task automatic goto(input int k);
        int guard = 0;
        while (n != k + 1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (n != k + 1) begin
            total++;
            bad++;
            $display("FAIL goto_timeout: position %0d reached %0d", k, n);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] d, input logic [7:0] s);
        chk({name, "_digit"}, {4'h0, DIGIT}, {4'h0, d});
        chk({name, "_seg"},   SEG,           s);
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] un);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        units     = un;
    endtask

    initial begin
        // 1. reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            lit("reset", 4'hF, 8'hFF);
            chk("reset_fs", {7'h0, frame_start}, 8'h00);
        end
        set_digits(4'h1, 4'h2, 4'h3, 4'h4);
        dp_en    = 4'h0;
        lz_blank = 1'b0;
        reset    = 1'b0;

        goto(0);  chk("fs_first", {7'h0, frame_start}, 8'h01);
                  lit("first_dead", 4'hF, 8'hFF);
        goto(1);  chk("fs_single", {7'h0, frame_start}, 8'h00);

        // 2. digit order and dead time
        goto(2);  lit("units_1234", 4'hE, 8'h99);
        goto(8);  lit("dead_slot1", 4'hF, 8'hFF);
        goto(12); lit("tens_1234", 4'hD, 8'hB0);
        goto(20); lit("hund_1234", 4'hB, 8'hA4);
        goto(28); lit("thou_1234", 4'h7, 8'hF9);

        // 3. leading-zero blanking
        lz_blank = 1'b1;
        set_digits(4'h0, 4'h0, 4'h0, 4'h7);
        goto(32); chk("fs_period", {7'h0, frame_start}, 8'h01);
        goto(36); lit("lz_units7", 4'hE, 8'hF8);
        goto(44); lit("lz_tens",   4'hD, 8'hFF);
        goto(52); lit("lz_hund",   4'hB, 8'hFF);
        goto(60); lit("lz_thou",   4'h7, 8'hFF);
        set_digits(4'h0, 4'h0, 4'h0, 4'h0);
        goto(68); lit("lz_zero_units", 4'hE, 8'hC0);
        goto(76); lit("lz_zero_tens",  4'hD, 8'hFF);
        set_digits(4'h0, 4'h1, 4'h0, 4'h0);
        goto(108); lit("lz_inner_tens", 4'hD, 8'hC0);
        goto(116); lit("lz_hund1",      4'hB, 8'hF9);
        goto(124); lit("lz_thou0",      4'h7, 8'hFF);

        // 4. tearing: change units mid-frame
        lz_blank = 1'b0;
        set_digits(4'h0, 4'h0, 4'h0, 4'h4);
        goto(132); lit("tear_before", 4'hE, 8'h99);
        units = 4'h5;
        goto(134); lit("tear_hold", 4'hE, 8'h99);
        goto(148); lit("tear_slot2", 4'hB, 8'hC0);
        goto(164); lit("tear_next", 4'hE, 8'h92);

        // 5. hex and decimal point
        units = 4'hA;
        goto(196); lit("hex_A", 4'hE, 8'h88);
        units = 4'h4;
        dp_en = 4'b0001;
        goto(228); lit("dp_units4", 4'hE, 8'h19);
        dp_en    = 4'b1000;
        lz_blank = 1'b1;
        goto(260); lit("dp_off_units", 4'hE, 8'h99);
        goto(284); lit("dp_blanked", 4'h7, 8'h7F);

        // 6. reset in slot 2 at cnt 5
        goto(308);
        reset = 1'b1;
        set_digits(4'h9, 4'h8, 4'h7, 4'h6);
        dp_en    = 4'h0;
        lz_blank = 1'b0;
        @(negedge clk);
        lit("midreset", 4'hF, 8'hFF);
        chk("midreset_fs", {7'h0, frame_start}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        goto(0); chk("restart_fs", {7'h0, frame_start}, 8'h01);
        goto(2); lit("restart_units", 4'hE, 8'h82);
        goto(10); lit("restart_tens", 4'hD, 8'hF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
